// File: rtl/dac_spi_pkg.sv
// Shared types and defaults for the serial DAC write master.
package dac_spi_pkg;

  localparam int unsigned DAC_W       = 24;
  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_T_CSH   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold,
    StGap
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_spi_tx.sv
// SPI write master for the serial DAC: one sample per handshake, shifted out MSB-first
// with registered cs/sclk/mosi and an enforced cs-high gap between frames.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int unsigned DATA_W  = DAC_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned T_CSH   = DEF_T_CSH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              sclk,
  output logic              mosi
);

  localparam int unsigned GapMax = max_u(T_CSH, CLK_DIV);
  localparam int unsigned DivW   = cnt_w(CLK_DIV);
  localparam int unsigned HalfW  = cnt_w(2 * DATA_W);
  localparam int unsigned GapW   = cnt_w(GapMax);

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(2 * DATA_W - 1);
  localparam logic [GapW-1:0]  HoldLast = GapW'(CLK_DIV - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(T_CSH - 1);

  state_e             state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [HalfW-1:0]   half_q, half_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;

  assign din_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (din_valid) begin
          // MSB goes straight onto the pin so it is valid in the first SHIFT cycle.
          state_d = StShift;
          mosi_d  = din[DATA_W-1];
          shreg_d = {din[DATA_W-2:0], 1'b0};
          cs_d    = 1'b0;
          div_d   = '0;
          half_d  = '0;
        end
      end

      StShift: begin
        cs_d = 1'b0;
        if (div_q == DivLast) begin
          div_d = '0;
          if (half_q == HalfLast) begin
            state_d = StHold;
            sclk_d  = 1'b0;
            gap_d   = '0;
          end else begin
            half_d = half_q + HalfW'(1);
            // Odd half = sclk high; leaving it starts the next bit slot with sclk falling.
            sclk_d = ~half_q[0];
            if (half_q[0]) begin
              mosi_d  = shreg_q[DATA_W-1];
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StHold: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        if (gap_q == HoldLast) begin
          state_d = StGap;
          gap_d   = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      StGap: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (gap_q == GapLast) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule
